// File: rtl/wishbone_to_avalon_bridge_pkg.sv
// Package: wb_avmm_bridge_pkg
// Shared definitions for the Wishbone classic -> Avalon-MM bridge.
//   state_t        : bridge FSM states (ERR is only reachable when the
//                    WB_AVMM_TIMEOUT_EN macro is defined)
//   tmo_cnt_width  : width of a counter that can hold 0..cycles
package wb_avmm_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    RDWAIT = 3'd2,
    ACK    = 3'd3,
    ERR    = 3'd4
  } state_t;

  function automatic int tmo_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wishbone_to_avalon_bridge_if.sv
// Bus interfaces used by the Wishbone -> Avalon-MM bridge.
//   wb_if   : Wishbone classic bus. slave modport = bridge side,
//             master modport = CPU/DMA side.
//             adr_i/dat_i/we_i/sel_i/stb_i/cyc_i toward the slave,
//             dat_o/ack_o/err_o back to the master.
//   avmm_if : Avalon-MM pipelined bus. master modport = bridge side,
//             slave modport = interconnect/peripheral side.
//             address/read/write/writedata/byteenable toward the slave,
//             readdata/waitrequest/readdatavalid back to the master.
interface wb_if #(
  parameter int BUS_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic [BUS_WIDTH-1:0]  adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_i;
  logic [BE_WIDTH-1:0]   sel_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;
  logic                  err_o;

  modport slave  (input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
                  output dat_o, ack_o, err_o);
  modport master (output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
                  input  dat_o, ack_o, err_o);
endinterface

interface avmm_if #(
  parameter int BUS_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic [BUS_WIDTH-1:0]  avmm_address;
  logic                  avmm_read;
  logic                  avmm_write;
  logic [DATA_WIDTH-1:0] avmm_writedata;
  logic [BE_WIDTH-1:0]   avmm_byteenable;
  logic [DATA_WIDTH-1:0] avmm_readdata;
  logic                  avmm_waitrequest;
  logic                  avmm_readdatavalid;

  modport master (output avmm_address, avmm_read, avmm_write, avmm_writedata,
                         avmm_byteenable,
                  input  avmm_readdata, avmm_waitrequest, avmm_readdatavalid);
  modport slave  (input  avmm_address, avmm_read, avmm_write, avmm_writedata,
                         avmm_byteenable,
                  output avmm_readdata, avmm_waitrequest, avmm_readdatavalid);
endinterface

// File: rtl/wishbone_to_avalon_bridge_watchdog.sv
// Module: wb_avmm_watchdog
// Transfer watchdog for the Wishbone -> Avalon-MM bridge. Only compiled
// when WB_AVMM_TIMEOUT_EN is defined (the bridge instantiates it only then).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear        : forces the count back to zero
//   en           : counts one per cycle while high
//   expired      : high during the cycle in which the TIMEOUT_CYCLES-th
//                  enabled cycle completes (only while en is high)
`ifdef WB_AVMM_TIMEOUT_EN
module wb_avmm_watchdog
  import wb_avmm_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  assign expired = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/wishbone_to_avalon_bridge.sv
// Module: wishbone_to_avalon_bridge
// Wishbone classic slave -> Avalon-MM pipelined master bridge, one
// outstanding transfer. All Avalon command outputs are registered and held
// stable while avmm_waitrequest is high; read data is qualified by
// avmm_readdatavalid.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   wb           : wb_if.slave   (adr_i, dat_i, we_i, sel_i, stb_i, cyc_i
//                                 in; dat_o, ack_o, err_o out)
//   avmm         : avmm_if.master (address/read/write/writedata/byteenable
//                                 out; readdata/waitrequest/readdatavalid in)
// Optional feature macro: WB_AVMM_TIMEOUT_EN -- adds a watchdog that aborts
// a stalled transfer after TIMEOUT_CYCLES with a one-cycle err_o pulse.
// Without it err_o is constant 0 and the bridge waits indefinitely.
module wishbone_to_avalon_bridge
  import wb_avmm_bridge_pkg::*;
#(
  parameter int BUS_WIDTH      = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic    clk_i,
  input  logic    rst_i,
  wb_if.slave     wb,
  avmm_if.master  avmm
);

  if (BE_WIDTH * 8 != DATA_WIDTH) begin : g_bad_be_width
    $error("BE_WIDTH must equal DATA_WIDTH/8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t state, state_nxt;

  logic [BUS_WIDTH-1:0]  adr_q,   adr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [BE_WIDTH-1:0]   be_q,    be_nxt;
  logic                  rd_q,    rd_nxt;
  logic                  wr_q,    wr_nxt;
  logic [DATA_WIDTH-1:0] dat_q,   dat_nxt;
  logic                  ack_q,   ack_nxt;
  // guard: the cycle after a response is issued, a still-high stb_i belongs
  // to the finished transfer and must not start a new one.
  logic                  guard_q, guard_nxt;
  // aborted: the master dropped cyc_i mid-transfer; the Avalon side still
  // completes (there is no Avalon abort) but no response is returned.
  logic                  abort_q, abort_nxt;

`ifdef WB_AVMM_TIMEOUT_EN
  logic err_q, err_nxt;
  logic wd_expired;

  wb_avmm_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state == IDLE),
    .en      ((state == CMD) || (state == RDWAIT)),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr_q;
    wdata_nxt = wdata_q;
    be_nxt    = be_q;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    dat_nxt   = dat_q;
    ack_nxt   = 1'b0;
    guard_nxt = 1'b0;
    abort_nxt = abort_q;
`ifdef WB_AVMM_TIMEOUT_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (wb.cyc_i && wb.stb_i && !guard_q) begin
          adr_nxt   = wb.adr_i;
          wdata_nxt = wb.dat_i;
          be_nxt    = wb.sel_i;
          rd_nxt    = !wb.we_i;
          wr_nxt    = wb.we_i;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (!wb.cyc_i) abort_nxt = 1'b1;
        // readdatavalid is deliberately not looked at until the command
        // has been accepted.
        if (!avmm.avmm_waitrequest) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = wr_q ? ACK : RDWAIT;
        end
`ifdef WB_AVMM_TIMEOUT_EN
        else if (wd_expired) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = ERR;
        end
`endif
      end
      RDWAIT: begin
        if (!wb.cyc_i) abort_nxt = 1'b1;
        if (avmm.avmm_readdatavalid) begin
          dat_nxt   = avmm.avmm_readdata;
          state_nxt = ACK;
        end
`ifdef WB_AVMM_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt = ERR;
        end
`endif
      end
      ACK: begin
        ack_nxt   = wb.cyc_i && !abort_q;
        guard_nxt = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
`ifdef WB_AVMM_TIMEOUT_EN
        err_nxt   = wb.cyc_i && !abort_q;
        guard_nxt = 1'b1;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      guard_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      adr_q   <= adr_nxt;
      wdata_q <= wdata_nxt;
      be_q    <= be_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      dat_q   <= dat_nxt;
      ack_q   <= ack_nxt;
      guard_q <= guard_nxt;
      abort_q <= abort_nxt;
    end
  end

`ifdef WB_AVMM_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end
  assign wb.err_o = err_q;
`else
  assign wb.err_o = 1'b0;
`endif

  assign wb.dat_o              = dat_q;
  assign wb.ack_o              = ack_q;
  assign avmm.avmm_address     = adr_q;
  assign avmm.avmm_read        = rd_q;
  assign avmm.avmm_write       = wr_q;
  assign avmm.avmm_writedata   = wdata_q;
  assign avmm.avmm_byteenable  = be_q;

endmodule

// File: tb/tb_wishbone_to_avalon_bridge.sv
// Testbench for wishbone_to_avalon_bridge. Acts as Wishbone master and
// Avalon slave; each transfer's expected cycle-by-cycle behaviour is derived
// from its wait-state count W and read-data delay D using the latency rules
// (request sampled at edge 0, command visible after edges 0..W, accept at
// edge W+1, read data at edge W+1+D, ack visible for one cycle after the
// following edge). A single compare process checks the DUT every cycle.
// Also honours WB_AVMM_TIMEOUT_EN (TIMEOUT_CYCLES = 8).
module tb_wishbone_to_avalon_bridge;
  localparam int BW  = 5;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if   #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .BE_WIDTH(BEW)) wb ();
  avmm_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .BE_WIDTH(BEW)) av ();

  wishbone_to_avalon_bridge #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .BE_WIDTH(BEW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb.slave),
    .avmm  (av.master)
  );

  int errors = 0;
  int checks = 0;

  // expected DUT state
  logic           chk_en    = 1'b0;
  logic           exp_read  = 1'b0;
  logic           exp_write = 1'b0;
  logic           exp_ack   = 1'b0;
  logic           exp_err   = 1'b0;
  logic           dat_known = 1'b1;
  logic [BW-1:0]  exp_adr   = '0;
  logic [DW-1:0]  exp_wdata = '0;
  logic [DW-1:0]  exp_dat   = '0;
  logic [BEW-1:0] exp_be    = '0;

  // observations for literal pins
  int             obs_cmd, obs_ack, obs_err;
  logic [DW-1:0]  obs_ack_dat, obs_wdata;
  logic [BW-1:0]  obs_adr;
  logic [BEW-1:0] obs_be;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("avmm_read",  64'(av.avmm_read),  64'(exp_read));
      check("avmm_write", 64'(av.avmm_write), 64'(exp_write));
      check("ack_o",      64'(wb.ack_o),      64'(exp_ack));
      check("err_o",      64'(wb.err_o),      64'(exp_err));
      if (exp_read || exp_write) begin
        check("avmm_address",    64'(av.avmm_address),    64'(exp_adr));
        check("avmm_byteenable", 64'(av.avmm_byteenable), 64'(exp_be));
        if (exp_write) check("avmm_writedata", 64'(av.avmm_writedata), 64'(exp_wdata));
      end
      if (dat_known) check("dat_o", 64'(wb.dat_o), 64'(exp_dat));
    end
  end

  task automatic observe();
    if (av.avmm_read || av.avmm_write) begin
      obs_cmd++;
      obs_adr   = av.avmm_address;
      obs_be    = av.avmm_byteenable;
      obs_wdata = av.avmm_writedata;
    end
    if (wb.ack_o) begin
      obs_ack++;
      obs_ack_dat = wb.dat_o;
    end
    if (wb.err_o) obs_err++;
  endtask

  task automatic clear_obs();
    obs_cmd = 0; obs_ack = 0; obs_err = 0;
    obs_ack_dat = '0; obs_wdata = '0; obs_adr = '0; obs_be = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'($urandom_range(0, 1));
      wb.we_i  = 1'($urandom_range(0, 1));
      wb.adr_i = BW'($urandom);
      av.avmm_waitrequest   = 1'($urandom_range(0, 1));
      av.avmm_readdatavalid = 1'b0;
      av.avmm_readdata      = $urandom;
      @(posedge clk); #1;
      exp_read = 1'b0; exp_write = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    end
  endtask

  // One Wishbone transfer; abort_at > 0 drops cyc_i from that edge onward.
  // stb_i stays high through the edge at which the master sees ack_o.
  task automatic run_txn(input logic we, input logic [BW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [BEW-1:0] sel,
                         input int w, input int d, input int abort_at,
                         input logic [DW-1:0] rdata);
    int a;
    a = we ? w + 1 : w + 1 + d;
    clear_obs();
    wb.we_i = we; wb.adr_i = adr; wb.dat_i = dat; wb.sel_i = sel;
    for (int e = 0; e <= a + 2; e++) begin
      wb.cyc_i = (abort_at == 0) || (e < abort_at);
      wb.stb_i = wb.cyc_i;
      if (e >= 1 && e <= w)  av.avmm_waitrequest = 1'b1;
      else if (e == w + 1)   av.avmm_waitrequest = 1'b0;
      else                   av.avmm_waitrequest = 1'($urandom_range(0, 1));
      if (!we && e == w + 1 + d) begin
        av.avmm_readdatavalid = 1'b1;
        av.avmm_readdata      = rdata;
      end else if (e >= 1 && e <= w + 1) begin
        av.avmm_readdatavalid = 1'($urandom_range(0, 1));
        av.avmm_readdata      = $urandom;
      end else begin
        av.avmm_readdatavalid = 1'b0;
        av.avmm_readdata      = $urandom;
      end
      @(posedge clk); #1;
      exp_read  = !we && (e <= w);
      exp_write = we && (e <= w);
      exp_adr   = adr; exp_wdata = dat; exp_be = sel;
      exp_ack   = (e == a + 1) && (abort_at == 0);
      exp_err   = 1'b0;
      if (!we && e == a) begin
        if (abort_at == 0) begin
          exp_dat   = rdata;
          dat_known = 1'b1;
        end else begin
          dat_known = 1'b0;
        end
      end
      observe();
    end
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
    av.avmm_waitrequest = 1'b0; av.avmm_readdatavalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_rand;
    logic rwe;
    int rw, rd, ra, rab;
    rst = 1'b1;
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0; wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0;
    av.avmm_readdata = '0; av.avmm_waitrequest = 0; av.avmm_readdatavalid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read",  64'(av.avmm_read),    64'd0);
    check("reset_write", 64'(av.avmm_write),   64'd0);
    check("reset_ack",   64'(wb.ack_o),        64'd0);
    check("reset_err",   64'(wb.err_o),        64'd0);
    check("reset_dat",   64'(wb.dat_o),        64'd0);
    check("reset_adr",   64'(av.avmm_address), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // 1: single write, no wait
    run_txn(1'b1, 5'h03, 32'hCAFE_F00D, 4'hF, 0, 1, 0, '0);
    check("t1_write_cycles", 64'(obs_cmd),   64'd1);
    check("t1_ack_cycles",   64'(obs_ack),   64'd1);
    check("t1_wdata",        64'(obs_wdata), 64'hCAFE_F00D);
    check("t1_adr",          64'(obs_adr),   64'h03);
    idle(2);

    // 2: read, 3 wait cycles, data 2 cycles after accept
    run_txn(1'b0, 5'h10, 32'h0, 4'hF, 3, 2, 0, 32'h1234_5678);
    check("t2_read_cycles", 64'(obs_cmd),     64'd4);
    check("t2_ack_cycles",  64'(obs_ack),     64'd1);
    check("t2_dat_at_ack",  64'(obs_ack_dat), 64'h1234_5678);
    idle(1);

    // 3: partial byte enables, 5 wait cycles
    run_txn(1'b1, 5'h0C, 32'hA5A5_0F0F, 4'b0101, 5, 1, 0, '0);
    check("t3_byteenable",   64'(obs_be),  64'h5);
    check("t3_write_cycles", 64'(obs_cmd), 64'd6);
    idle(1);

    // 4: cyc_i dropped during RDWAIT, then a write
    run_txn(1'b0, 5'h07, 32'h0, 4'hF, 1, 3, 3, 32'hDEAD_BEEF);
    check("t4_abort_no_ack", 64'(obs_ack), 64'd0);
    check("t4_read_cycles",  64'(obs_cmd), 64'd2);
    run_txn(1'b1, 5'h08, 32'h0BAD_F00D, 4'hC, 0, 1, 0, '0);
    check("t4_next_ack", 64'(obs_ack), 64'd1);
    idle(2);

    // 6: stuck waitrequest
`ifdef WB_AVMM_TIMEOUT_EN
    clear_obs();
    wb.we_i = 1'b0; wb.adr_i = 5'h1F; wb.sel_i = 4'hF;
    for (int e = 0; e <= TMO + 2; e++) begin
      wb.cyc_i = 1'b1; wb.stb_i = 1'b1;
      av.avmm_waitrequest = 1'b1; av.avmm_readdatavalid = 1'b0;
      @(posedge clk); #1;
      exp_read = (e < TMO); exp_write = 1'b0; exp_ack = 1'b0;
      exp_err = (e == TMO + 1); exp_adr = 5'h1F; exp_be = 4'hF;
      observe();
    end
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; av.avmm_waitrequest = 1'b0;
    check("t6_read_cycles", 64'(obs_cmd), 64'(TMO));
    check("t6_err_pulses",  64'(obs_err), 64'd1);
    check("t6_no_ack",      64'(obs_ack), 64'd0);
    // late read data in IDLE must be ignored
    av.avmm_readdatavalid = 1'b1; av.avmm_readdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    exp_err = 1'b0;
    av.avmm_readdatavalid = 1'b0;
    idle(2);
`else
    run_txn(1'b0, 5'h1F, 32'h0, 4'hF, 20, 1, 0, 32'h0F0F_1234);
    check("t6_err_count",   64'(obs_err), 64'd0);
    check("t6_read_cycles", 64'(obs_cmd), 64'd21);
    idle(2);
`endif

    // 5: asynchronous reset while in CMD
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 5'h0A; wb.sel_i = 4'hF;
    av.avmm_waitrequest = 1'b1; av.avmm_readdatavalid = 1'b0;
    @(posedge clk); #1;
    exp_read = 1'b1; exp_adr = 5'h0A; exp_be = 4'hF; exp_ack = 1'b0;
    @(posedge clk); #1;
    check("t5_read_before_rst", 64'(av.avmm_read), 64'd1);
    #2;
    rst = 1'b1;
    exp_read = 1'b0; exp_dat = '0; dat_known = 1'b1;
    #1;
    check("t5_read",  64'(av.avmm_read),       64'd0);
    check("t5_write", 64'(av.avmm_write),      64'd0);
    check("t5_adr",   64'(av.avmm_address),    64'd0);
    check("t5_wdata", 64'(av.avmm_writedata),  64'd0);
    check("t5_be",    64'(av.avmm_byteenable), 64'd0);
    check("t5_dat",   64'(wb.dat_o),           64'd0);
    check("t5_ack",   64'(wb.ack_o),           64'd0);
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; av.avmm_waitrequest = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    run_txn(1'b1, 5'h11, 32'h1357_9BDF, 4'hF, 1, 1, 0, '0);
    check("t5_after_rst_ack", 64'(obs_ack), 64'd1);

    // randomized traffic
    n_rand = 80;
    for (int i = 0; i < n_rand; i++) begin
      rwe = 1'($urandom_range(0, 1));
      rw  = $urandom_range(0, 3);
      rd  = $urandom_range(1, 3);
      ra  = rwe ? rw + 1 : rw + 1 + rd;
      rab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ra) : 0;
      run_txn(rwe, BW'($urandom), $urandom, BEW'($urandom), rw, rd, rab, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
